// File: rtl/fp_to_int_conv.sv
// Iterative IEEE-754 single to signed 32-bit integer converter, round-to-nearest-even.
// Denormals flush to zero; valid/ready handshake on both sides.
module fp_to_int_conv #(
    parameter logic [31:0] NAN_RESULT = 32'h80000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_inexact,
    output logic        out_invalid
);

    typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

    state_t             state_q, state_d;
    logic               sign_q, sign_d;
    logic               left_q, left_d;
    logic               g_q, g_d;
    logic               st_q, st_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [31:0]        mag_q, mag_d;
    logic signed [31:0] data_q, data_d;
    logic               inexact_q, inexact_d;
    logic               invalid_q, invalid_d;

    logic [7:0]         exp_w;
    logic [22:0]        man_w;
    logic               accept_w;

    function automatic logic [31:0] round_ne(input logic [31:0] mag,
                                             input logic g, input logic st);
        logic inc;
        inc = g & (st | mag[0]);
        return mag + {31'd0, inc};
    endfunction

    function automatic logic signed [31:0] apply_sign(input logic [31:0] mag,
                                                      input logic s);
        return s ? -$signed(mag) : $signed(mag);
    endfunction

    assign exp_w       = in_data[30:23];
    assign man_w       = in_data[22:0];
    assign in_ready    = (state_q == IDLE) && !rst;
    assign accept_w    = in_valid && in_ready;
    assign out_valid   = (state_q == DONE);
    assign out_data    = data_q;
    assign out_inexact = inexact_q;
    assign out_invalid = invalid_q;

    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        left_d    = left_q;
        g_d       = g_q;
        st_d      = st_q;
        cnt_d     = cnt_q;
        mag_d     = mag_q;
        data_d    = data_q;
        inexact_d = inexact_q;
        invalid_d = invalid_q;
        unique case (state_q)
            IDLE: begin
                if (accept_w) begin
                    sign_d = in_data[31];
                    g_d    = 1'b0;
                    st_d   = 1'b0;
                    mag_d  = {8'd0, 1'b1, man_w};
                    // Specials resolve immediately; everything else walks the shifter.
                    if (exp_w == 8'd255 && man_w != 23'd0) begin
                        data_d    = NAN_RESULT;
                        inexact_d = 1'b0;
                        invalid_d = 1'b1;
                        state_d   = DONE;
                    end else if (exp_w == 8'd158 && in_data[31] && man_w == 23'd0) begin
                        data_d    = 32'h80000000;
                        inexact_d = 1'b0;
                        invalid_d = 1'b0;
                        state_d   = DONE;
                    end else if (exp_w >= 8'd158) begin
                        data_d    = in_data[31] ? 32'h80000000 : 32'h7FFFFFFF;
                        inexact_d = 1'b0;
                        invalid_d = 1'b1;
                        state_d   = DONE;
                    end else if (exp_w < 8'd126) begin
                        data_d    = '0;
                        inexact_d = (exp_w != 8'd0) || (man_w != 23'd0);
                        invalid_d = 1'b0;
                        state_d   = DONE;
                    end else if (exp_w >= 8'd150) begin
                        left_d  = 1'b1;
                        cnt_d   = exp_w[4:0] - 5'd22;
                        state_d = (exp_w == 8'd150) ? ROUND : SHIFT;
                    end else begin
                        left_d  = 1'b0;
                        cnt_d   = 5'd22 - exp_w[4:0];
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (left_q) begin
                    mag_d = mag_q << 1;
                end else begin
                    st_d  = st_q | g_q;
                    g_d   = mag_q[0];
                    mag_d = mag_q >> 1;
                end
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) state_d = ROUND;
            end
            ROUND: begin
                data_d    = apply_sign(round_ne(mag_q, g_q, st_q), sign_q);
                inexact_d = g_q | st_q;
                invalid_d = 1'b0;
                state_d   = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            inexact_q <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            inexact_q <= inexact_d;
            invalid_q <= invalid_d;
        end
    end

    // Working registers need no reset: IDLE reloads them on every accept.
    always_ff @(posedge clk) begin
        sign_q <= sign_d;
        left_q <= left_d;
        g_q    <= g_d;
        st_q   <= st_d;
        cnt_q  <= cnt_d;
        mag_q  <= mag_d;
    end

endmodule

// File: tb/tb_fp_to_int_conv.sv
// Scoreboard bench for fp_to_int_conv: directed floats with hand-computed integers.
module tb_fp_to_int_conv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        out_inexact;
    logic        out_invalid;

    typedef struct {
        logic [31:0] data;
        logic        inex;
        logic        inv;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic prev_valid = 1'b0;

    fp_to_int_conv #(.NAN_RESULT(32'h80000000)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_inexact(out_inexact),
        .out_invalid(out_invalid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops on handshake, checks latency at the rising edge of out_valid.
    always @(negedge clk) begin
        if (out_valid) begin
            if (q.size() == 0) begin
                if (!prev_valid) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %h expected no output (cycle %0d)", out_data, cyc);
                end
            end else begin
                if (!prev_valid) check("latency", 32'(cyc - q[0].acc), 32'(q[0].lat));
                check("out_data", out_data, q[0].data);
                check("out_inexact", {31'd0, out_inexact}, {31'd0, q[0].inex});
                check("out_invalid", {31'd0, out_invalid}, {31'd0, q[0].inv});
                check("in_ready_in_done", {31'd0, in_ready}, 32'd0);
                if (out_ready) void'(q.pop_front());
            end
        end
        prev_valid = out_valid;
    end

    task automatic send(input logic [31:0] d, input logic [31:0] ed, input logic ei,
                        input logic ev, input int lat, input bit push);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready got 0 expected 1 for input %h", d);
            return;
        end
        in_valid = 1'b1;
        in_data  = d;
        if (push) q.push_back('{data: ed, inex: ei, inv: ev, lat: lat, acc: cyc});
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (q.size() != 0 && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending got %0d expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        int w;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_flags", {30'd0, out_inexact, out_invalid}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Ties to even and right-shift path
        send(32'h3FC00000, 32'h00000002, 1'b1, 1'b0, 25, 1'b1);
        send(32'h40200000, 32'h00000002, 1'b1, 1'b0, 24, 1'b1);
        send(32'hC0200000, 32'hFFFFFFFE, 1'b1, 1'b0, 24, 1'b1);
        send(32'h40600000, 32'h00000004, 1'b1, 1'b0, 24, 1'b1);
        send(32'hBF800000, 32'hFFFFFFFF, 1'b0, 1'b0, 25, 1'b1);
        // Left-shift path
        send(32'h4EFFFFFF, 32'h7FFFFF80, 1'b0, 1'b0, 9, 1'b1);
        send(32'h4B000000, 32'h00800000, 1'b0, 1'b0, 2, 1'b1);
        // Range edges
        send(32'hCF000000, 32'h80000000, 1'b0, 1'b0, 1, 1'b1);
        send(32'h4F000000, 32'h7FFFFFFF, 1'b0, 1'b1, 1, 1'b1);
        send(32'hFF800000, 32'h80000000, 1'b0, 1'b1, 1, 1'b1);
        send(32'h7FC00000, 32'h80000000, 1'b0, 1'b1, 1, 1'b1);
        // Small values
        send(32'h3F000000, 32'h00000000, 1'b1, 1'b0, 26, 1'b1);
        send(32'h3F000001, 32'h00000001, 1'b1, 1'b0, 26, 1'b1);
        send(32'h00000001, 32'h00000000, 1'b1, 1'b0, 1, 1'b1);
        send(32'h80000000, 32'h00000000, 1'b0, 1'b0, 1, 1'b1);
        wait_drain();

        // Backpressure: hold result for 5 cycles, then release and go again
        @(posedge clk);
        #1 out_ready = 1'b0;
        send(32'h40200000, 32'h00000002, 1'b1, 1'b0, 24, 1'b1);
        w = 0;
        while (!out_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        check("bp_valid_seen", {31'd0, out_valid}, 32'd1);
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_valid", {31'd0, out_valid}, 32'd0);
        check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
        send(32'h4B000000, 32'h00800000, 1'b0, 1'b0, 2, 1'b1);
        wait_drain();

        // Reset in the middle of a shift; the aborted result must never appear
        send(32'h3FC00000, 32'h0, 1'b0, 1'b0, 0, 1'b0);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_out_data", out_data, 32'd0);
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (30) @(negedge clk);
        send(32'hC0200000, 32'hFFFFFFFE, 1'b1, 1'b0, 24, 1'b1);
        wait_drain();

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: cycle %0d expected completion", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fp_to_int_conv.md
Name: fp_to_int_conv

Overview:
- Iterative converter from IEEE-754 single-precision to signed 32-bit two's-complement integer.
- Rounding is round-to-nearest-even, matching the adder's rounding rules.
- Denormals are flushed to zero, as in the adder.
- Sits downstream of the FP add datapath and unpacks a float result for integer consumers, using a valid/ready handshake on both sides.

Parameters:
- NAN_RESULT, 32'h80000000, integer value returned for any NaN input.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input float valid.
- in_ready  out  1  converter can accept input.
- in_data  in  32  IEEE single: sign [31], exponent [30:23], mantissa [22:0].
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  32  signed integer result.
- out_inexact  out  1  result differs from the exact input value.
- out_invalid  out  1  NaN, infinity or out-of-range input.

Behaviour:
- Reset: state=IDLE; out_valid=0, out_data=0, out_inexact=0, out_invalid=0; in_ready=0 while rst is high.
- Reset mid-operation aborts the conversion; no output is produced.
- in_ready = (state==IDLE) and not rst. An input is accepted when in_valid && in_ready.
- FSM states and transitions:
  - IDLE: on accept, register s/e/m and classify (below).
  - SHIFT: one bit of shift per cycle.
  - ROUND: round and apply sign.
  - DONE: out_valid=1.
- Classification at accept, with e = in_data[30:23], m = in_data[22:0], sig = {1,m} (24 bits) if e!=0:
  - e==255 && m!=0 (NaN): result NAN_RESULT, invalid=1. Go to DONE.
  - e==158 && s==1 && m==0: result 32'h80000000, invalid=0, inexact=0. Go to DONE.
  - e>=158, all other cases including infinity: saturate to 7FFFFFFF (s=0) or 80000000 (s=1), invalid=1. Go to DONE.
  - e<126, including zero and denormals: result 0, inexact = (e!=0 || m!=0). Go to DONE.
  - 150<=e<=157: mag=sig, dir=left, cnt=e-150. Go to SHIFT, or straight to ROUND if cnt==0.
  - 126<=e<=149: mag=sig, dir=right, cnt=150-e (1..24). Go to SHIFT.
- Working registers: mag (32 bits), guard g, sticky st, cnt (5 bits). g and st are cleared on accept.
- SHIFT, left: mag<<=1.
- SHIFT, right: st|=g, g=mag[0], mag>>=1.
- SHIFT, both directions: cnt-=1; move to ROUND when cnt reaches 1 at the start of the cycle.
- ROUND:
  - inc = g && (st || mag[0]); mag' = mag + inc.
  - out_data = s ? -mag' : mag'; inexact = g || st; invalid=0.
  - mag' never exceeds 2^31-128, so no overflow is possible here.
- -0.0 gives 0 with no flags.
- DONE: out_valid=1 with data and flags held stable until out_ready. On out_valid && out_ready, go to IDLE next cycle; out_valid drops.
- No input is accepted in the same cycle as an output handoff.
- Latency from the accept edge to out_valid high:
  - Special cases: 1 cycle.
  - Shift path: cnt+2 cycles.
  - Maximum 26 cycles (e=126).
- Output registers update only on the transition into DONE.

Test Plan:
- Ties to even: 0x3FC00000 (1.5) -> 2, inexact=1, out_valid 25 cycles after accept. 0x40200000 (2.5) -> 2, inexact=1. 0xC0200000 (-2.5) -> 0xFFFFFFFE.
- Left shift, exact: 0x4EFFFFFF -> 0x7FFFFF80, flags 0, latency 9. 0x4B000000 (2^23, cnt=0) -> 0x00800000, latency 2.
- Range edges:
  - 0xCF000000 -> 0x80000000, invalid=0.
  - 0x4F000000 -> 0x7FFFFFFF, invalid=1.
  - 0xFF800000 (-inf) -> 0x80000000, invalid=1.
  - 0x7FC00000 (NaN) -> NAN_RESULT, invalid=1.
  - Each of these with latency 1.
- Small values:
  - 0x3F000000 (0.5) -> 0, inexact=1.
  - 0x3F000001 -> 1, inexact=1.
  - 0x00000001 (denormal) -> 0, inexact=1.
  - 0x80000000 (-0.0) -> 0, flags 0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid, out_data and flags stable, in_ready=0 throughout. Release -> IDLE next cycle, then a back-to-back second conversion completes correctly.
- Reset mid-SHIFT: assert rst for 1 cycle during a 1.5 conversion -> out_valid=0 and out_data=0 next cycle, in_ready=1 after rst falls, the aborted result is never emitted, and a new input converts correctly.
